// File: rtl/seq_div_if.sv
// Request/result handshake bundle for the iterative unsigned divider.
// The slave modport is the divider side; the master modport is the requester/consumer side.
interface seq_div_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
// A zero divisor skips iteration and reports all-ones quotient with the dividend as remainder.
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_div_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH:0]   r, r_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic             dbz, dbz_n;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            r     <= r_n;
            dvs   <= dvs_n;
            quo   <= quo_n;
            rem   <= rem_n;
            dbz   <= dbz_n;
        end
    end

    // Compare/subtract at WIDTH+1 bits so the shifted-in top bit never overflows.
    assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
    assign r_diff  = r_shift - {1'b0, dvs};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        r_n     = r;
        dvs_n   = dvs;
        quo_n   = quo;
        rem_n   = rem;
        dbz_n   = dbz;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        quo_n   = '1;
                        rem_n   = bus.dividend;
                        dbz_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        dvs_n   = bus.divisor;
                        q_n     = bus.dividend;
                        r_n     = '0;
                        cnt_n   = '0;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_shift >= {1'b0, dvs}) begin
                    r_n = r_diff;
                    q_n = {q[WIDTH-2:0], 1'b1};
                end else begin
                    r_n = r_shift;
                    q_n = {q[WIDTH-2:0], 1'b0};
                end
                cnt_n = cnt + CW'(1);
                // Results are captured into separate output registers so they hold outside DONE.
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt_n   = '0;
                    quo_n   = q_n;
                    rem_n   = r_n[WIDTH-1:0];
                    dbz_n   = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: doc/seq_div.md
# seq_div

Iterative unsigned restoring divider with valid/ready handshakes on both sides. It is the sequential arithmetic companion to the combinational add/multiply helpers used in datapath modules. It takes one quotient bit per cycle, so it suits control-path and configuration arithmetic where area matters more than throughput. It sits between a requesting datapath stage and a consuming stage.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request operands valid
- in_ready  output  1  divider can accept a request
- dividend  input  WIDTH  unsigned numerator, sampled on accept
- divisor  input  WIDTH  unsigned denominator, sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  floor(dividend/divisor)
- remainder  output  WIDTH  dividend mod divisor
- div_by_zero  output  1  divisor was zero for this result

## Operation
- The divider has one clock, clk. Reset rst_n is synchronous and active-low.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready.
  - On accept with divisor≠0: latch the operands, clear the partial remainder R (WIDTH+1 bits), load the quotient shift register Q with dividend, set iteration counter to 0, then go to BUSY.
  - On accept with divisor==0: go directly to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- BUSY (in_ready=0): each cycle performs one restoring step:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}
  - Shift Q left by one.
  - If R' ≥ divisor: R = R' − divisor and Q[0]=1. Otherwise R = R' and Q[0]=0.
  - Compute the compare/subtract at WIDTH+1 bits so there is no overflow.
  - Counter increments each step. The step with counter==WIDTH−1 is the last; then go to DONE.
- DONE:
  - out_valid=1, quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0 (for nonzero-divisor operations).
  - On out_valid && out_ready, go to IDLE.
  - in_ready=0 in DONE, so a new request is never accepted in the same cycle a result is consumed.
- Outputs quotient, remainder and div_by_zero stay stable while out_valid=1 and out_ready=0.
- Outside DONE, quotient/remainder/div_by_zero hold their last values. They are don't-care to consumers.
- Reset (rst_n=0 at an edge), from any state including mid-BUSY or DONE:
  - state=IDLE, counter=0, Q=0, R=0.
  - Any in-flight operation is discarded with no output.
- Reset values: in_ready=1 (first cycle after reset release), out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- in_valid while in_ready=0 is ignored. The requester must hold the request until it is accepted.

## Timing
- Accept at the edge ending cycle 0.
- Nonzero divisor:
  - BUSY occupies cycles 1..WIDTH.
  - out_valid=1 from cycle WIDTH+1.
  - Latency from accept edge to out_valid is WIDTH+1 cycles.
- Zero divisor: out_valid=1 in cycle 1 (latency 1).
- With out_ready held at 1:
  - Result consumed at the edge ending cycle WIDTH+1.
  - in_ready=1 in cycle WIDTH+2.
  - Peak throughput: 1 operation per WIDTH+2 cycles.
- in_ready and out_valid are registered-state decodes only, with no combinational path from in_valid or out_ready.

## Test plan
- Use WIDTH=8 throughout.
- Basic divide: reset, then dividend=100, divisor=7 accepted in cycle 0, out_ready=1.
  - Required: out_valid=1 first in cycle 9, quotient=14, remainder=2, div_by_zero=0.
  - Required: in_ready=1 in cycle 10.
- Extremes: 255/1 → q=255 r=0. 255/255 → q=1 r=0. 3/10 → q=0 r=3. 0/5 → q=0 r=0.
  - Each result at latency 9.
- Divide by zero: dividend=5, divisor=0.
  - Required: out_valid in cycle 1, quotient=255, remainder=5, div_by_zero=1.
  - A following 9/3 gives q=3 r=0 with div_by_zero=0.
- Backpressure:
  - 200/9 with out_ready=0 for 5 cycles after out_valid rises: out_valid stays 1, q=22 r=2 stable, in_ready=0, and an asserted in_valid is not accepted.
  - Raise out_ready: consumed in that cycle, in_ready=1 the next cycle.
- Reset mid-operation:
  - Accept 100/7, assert rst_n=0 in cycle 4 for one edge.
  - Required: next cycle out_valid=0, in_ready=1, quotient=0, remainder=0. No result is ever produced for the aborted request.
  - Then 50/6 → q=8 r=2 at normal latency.
- Randomized back-to-back: 1000 random pairs with random out_ready stalls, compared against a / and % reference model.
  - Required: no lost or duplicated results, and the latency rule holds.
